// File: rtl/key_scan_ctrl.sv
// 4x4 key matrix scanner: column drive, debounce, auto-repeat and a single-entry
// event register with ready/valid handshake and overflow pulse.
module key_scan_ctrl #(
  parameter logic                 KEY_DOWN_VAL = 1'b0,
  parameter int unsigned          CNT_WIDTH    = 24,
  parameter logic [CNT_WIDTH-1:0] SCAN_DIV     = 24'd50000,
  parameter logic [CNT_WIDTH-1:0] DEB_CNT      = 24'd1000000,
  parameter logic [CNT_WIDTH-1:0] REP_CNT      = 24'd16000000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] col,
  input  logic [3:0] row,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [3:0] ev_code,
  output logic       ev_press,
  output logic       ev_rep,
  output logic       ev_ovf
);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic                 KEY_UP_VAL = ~KEY_DOWN_VAL;
  localparam logic [CNT_WIDTH-1:0] ONE        = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] SCAN_LAST  = SCAN_DIV - ONE;
  localparam logic [CNT_WIDTH-1:0] DEB_LAST   = DEB_CNT - ONE;
  localparam logic [CNT_WIDTH-1:0] REP_LAST   = REP_CNT - ONE;

  logic [3:0]           row_m, row_s;
  state_t               state, state_nx;
  logic [1:0]           col_idx, col_idx_nx;
  logic [1:0]           row_idx, row_idx_nx;
  logic [CNT_WIDTH-1:0] cnt, cnt_nx;
  logic                 emit, emit_press, emit_rep;
  logic [3:0]           down_vec;
  logic                 key_down;
  logic [1:0]           low_row;

  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    logic [3:0] v;
    v      = {4{KEY_UP_VAL}};
    v[idx] = KEY_DOWN_VAL;
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      row_m <= {4{KEY_UP_VAL}};
      row_s <= {4{KEY_UP_VAL}};
    end else begin
      row_m <= row;
      row_s <= row_m;
    end
  end

  always_comb begin
    down_vec = row_s ^ {4{KEY_UP_VAL}};
    key_down = down_vec[row_idx];
    low_row  = 2'd0;
    // Walk downwards so the lowest pressed row wins.
    for (int unsigned i = 4; i > 0; i--) begin
      if (down_vec[i-1]) low_row = 2'(i - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= SCAN;
      col_idx <= 2'd0;
      row_idx <= 2'd0;
      cnt     <= '0;
      col     <= col_drive(2'd0);
    end else begin
      state   <= state_nx;
      col_idx <= col_idx_nx;
      row_idx <= row_idx_nx;
      cnt     <= cnt_nx;
      col     <= col_drive(col_idx_nx);
    end
  end

  always_comb begin
    state_nx   = state;
    col_idx_nx = col_idx;
    row_idx_nx = row_idx;
    cnt_nx     = cnt + ONE;
    emit       = 1'b0;
    emit_press = 1'b0;
    emit_rep   = 1'b0;
    case (state)
      SCAN: begin
        if (cnt == SCAN_LAST) begin
          cnt_nx = '0;
          if (|down_vec) begin
            row_idx_nx = low_row;
            state_nx   = DEBOUNCE;
          end else begin
            col_idx_nx = col_idx + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (!key_down) begin
          state_nx   = SCAN;
          col_idx_nx = col_idx + 2'd1;
          cnt_nx     = '0;
        end else if (cnt == DEB_LAST) begin
          state_nx   = HELD;
          cnt_nx     = '0;
          emit       = 1'b1;
          emit_press = 1'b1;
        end
      end
      HELD: begin
        if (!key_down) begin
          state_nx = RELEASE;
          cnt_nx   = '0;
        end else if (REP_CNT == '0) begin
          cnt_nx = cnt;
        end else if (cnt == REP_LAST) begin
          cnt_nx     = '0;
          emit       = 1'b1;
          emit_press = 1'b1;
          emit_rep   = 1'b1;
        end
      end
      RELEASE: begin
        if (key_down) begin
          state_nx = HELD;
          cnt_nx   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nx   = SCAN;
          col_idx_nx = col_idx + 2'd1;
          cnt_nx     = '0;
          emit       = 1'b1;
        end
      end
      default: begin
        state_nx = SCAN;
        cnt_nx   = '0;
      end
    endcase
  end

  // A handshake in the same cycle frees the slot, so the new event is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      ev_valid <= 1'b0;
      ev_code  <= '0;
      ev_press <= 1'b0;
      ev_rep   <= 1'b0;
      ev_ovf   <= 1'b0;
    end else begin
      ev_ovf <= 1'b0;
      if (emit) begin
        if (!ev_valid || ev_ready) begin
          ev_valid <= 1'b1;
          ev_code  <= {row_idx, col_idx};
          ev_press <= emit_press;
          ev_rep   <= emit_rep;
        end else begin
          ev_ovf <= 1'b1;
        end
      end else if (ev_ready) begin
        ev_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/key_scan_ctrl.md
KEY_SCAN_CTRL -- requirements
Module: key_scan_ctrl

Interface
REQ-001 SHALL have parameter KEY_DOWN_VAL, default 1'b0, level meaning "active column driven / key pressed on row".
REQ-002 SHALL have parameter CNT_WIDTH, default 24, width of all internal counters.
REQ-003 SHALL have parameter SCAN_DIV, default 24'd50000, column dwell in clk cycles (1 ms at 50 MHz), legal range >= 4.
REQ-004 SHALL have parameter DEB_CNT, default 24'd1000000, press/release debounce length in clk cycles (20 ms), legal range >= 1.
REQ-005 SHALL have parameter REP_CNT, default 24'd16000000, auto-repeat period in clk cycles; 0 disables repeat.
REQ-006 SHALL have port clk, input, 1 bit, sole clock.
REQ-007 SHALL have port rst, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-008 SHALL have port col, output, 4 bits: matrix column drive.
REQ-009 SHALL have port row, input, 4 bits: asynchronous matrix row sense.
REQ-010 SHALL have port ev_valid, output, 1 bit: event register holds an unconsumed event.
REQ-011 SHALL have port ev_ready, input, 1 bit: consumer accepts the event.
REQ-012 SHALL have port ev_code, output, 4 bits: {row_idx[1:0], col_idx[1:0]}.
REQ-013 SHALL have port ev_press, output, 1 bit: 1 press/repeat, 0 release.
REQ-014 SHALL have port ev_rep, output, 1 bit: 1 for an auto-repeat event.
REQ-015 SHALL have port ev_ovf, output, 1 bit: one-cycle pulse when an event is dropped.

Function
REQ-016 SHALL synchronize row through two flops; all decisions use the synchronized value (row_s).
REQ-017 SHALL drive col[col_idx] = KEY_DOWN_VAL and all other bits = ~KEY_DOWN_VAL, registered.
REQ-018 SHALL implement FSM states SCAN, DEBOUNCE, HELD, RELEASE.
REQ-019 In SCAN, SHALL count dwell 0..SCAN_DIV-1 per column; at dwell == SCAN_DIV-1, col_idx advances (3 wraps to 0) and dwell clears.
REQ-020 At dwell == SCAN_DIV-1 in SCAN, if any row_s bit == KEY_DOWN_VAL, SHALL latch the lowest such row index as row_idx, keep col_idx (no advance), clear counter, enter DEBOUNCE.
REQ-021 In DEBOUNCE, col frozen; if row_s[row_idx] != KEY_DOWN_VAL, SHALL return to SCAN with col_idx+1 and dwell 0, no event.
REQ-022 In DEBOUNCE, key down with counter == DEB_CNT-1 SHALL enter HELD, emit press event (ev_press=1, ev_rep=0), clear counter.
REQ-023 In HELD, key down and REP_CNT != 0 SHALL increment counter; at counter == REP_CNT-1, emit repeat event (ev_press=1, ev_rep=1), clear counter.
REQ-024 In HELD, key up SHALL enter RELEASE with counter cleared.
REQ-025 In RELEASE, key down again SHALL return to HELD with counter cleared, no event.
REQ-026 In RELEASE, key up with counter == DEB_CNT-1 SHALL emit release event (ev_press=0, ev_rep=0), enter SCAN with col_idx+1, dwell 0.
REQ-027 Other rows/columns pressed while in DEBOUNCE/HELD/RELEASE SHALL be ignored (single-key rollover).
REQ-028 Event emission SHALL load ev_code/ev_press/ev_rep and set ev_valid the following cycle.
REQ-029 ev_valid SHALL clear on the cycle after ev_valid && ev_ready with no new event.
REQ-030 Simultaneous ev_ready handshake and new event SHALL load the new event, ev_valid stays 1, no overflow.
REQ-031 New event while ev_valid && !ev_ready SHALL be dropped, existing event unchanged, ev_ovf pulsed 1 cycle.
REQ-032 Illegal FSM encoding SHALL recover to SCAN.

Reset
REQ-033 rst high on a clk edge SHALL set state SCAN, col_idx 0, dwell/counter 0, sync flops ~KEY_DOWN_VAL, ev_valid 0, ev_code 0, ev_press 0, ev_rep 0, ev_ovf 0, col = {3'b111, 1'b0} (KEY_DOWN_VAL=0).
REQ-034 rst asserted mid-DEBOUNCE/HELD SHALL abort without emitting any event; pending ev_valid cleared.

Verification (SCAN_DIV=4, DEB_CNT=8, REP_CNT=20, KEY_DOWN_VAL=0, ev_ready=1 unless noted)
REQ-035 No key: col cycles 1110,1101,1011,0111 every 4 clk, ev_valid never 1.
REQ-036 row[2] low while col_idx=1, held 60 clk then released 20 clk: one press ev_code=4'b1001, repeat events every 20 clk, one release ev_code=4'b1001 ev_press=0.
REQ-037 row[0] low for 5 clk during col 3 dwell: no event, scan resumes at col 0.
REQ-038 Bounce in HELD: key up 3 clk then down: no release event, HELD resumes.
REQ-039 ev_ready=0, press then release: press event retained, release dropped, ev_ovf one-cycle pulse.
REQ-040 rows 1 and 3 low simultaneously on col 2: ev_code=4'b0110; rst in HELD: ev_valid 0, col=1110 next cycle.
